wb_led_timer: RTL and testbench
===============================

WB_LED_TIMER -- requirements
Module: wb_led_timer

Interface
REQ-001 SHALL provide parameter LedWidth, default 4, giving the number of LED outputs (1..32).
REQ-002 SHALL provide parameter CmpReset, default 64'hFFFF_FFFF_FFFF_FFFF, giving the reset value of the compare register.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk_i input 1 is the sole clock; reset_i input 1 is the synchronous active-high reset.
REQ-004 SHALL have wb_addr_i input 30, word address; only bits [2:0] are decoded.
REQ-005 SHALL have wb_data_i input 32, write data.
REQ-006 SHALL have wb_sel_i input 4, byte enables.
REQ-007 SHALL have wb_cyc_i, wb_stb_i and wb_we_i, each input 1: Wishbone pipelined cycle, strobe and write enable.
REQ-008 SHALL have wb_data_o output 32, read data, valid with ack.
REQ-009 SHALL have wb_ack_o, wb_err_o and wb_stall_o, each output 1: acknowledge, error and stall.
REQ-010 SHALL have leds_o output LedWidth, the LED register value.
REQ-011 SHALL have irq_o output 1, the timer interrupt, level-sensitive.

Function
REQ-012 SHALL hold wb_stall_o at 0 at all times; a request is accepted in any cycle where wb_cyc_i and wb_stb_i are both 1.
REQ-013 SHALL assert exactly one of wb_ack_o or wb_err_o for exactly one cycle, the cycle after acceptance; back-to-back requests SHALL be acknowledged back-to-back.
REQ-014 SHALL decode the register map on wb_addr_i[2:0]:
- 0: LED (rw, bits [LedWidth-1:0], upper bits read 0).
- 1: MTIME_LO (rw).
- 2: MTIME_HI (rw).
- 3: MTIMECMP_LO (rw).
- 4: MTIMECMP_HI (rw).
- 5: CTRL (rw; bit0 irq enable, bit1 count enable, other bits read 0).
- 6 and 7: unmapped.
REQ-015 SHALL respond to an access to offset 6 or 7 with wb_err_o instead of wb_ack_o, with no state change and wb_data_o equal to 0.
REQ-016 SHALL apply writes per byte lane according to wb_sel_i; a write with wb_sel_i equal to 0 SHALL be acknowledged with no state change.
REQ-017 SHALL return the full 32-bit word on reads regardless of wb_sel_i, sampled in the acceptance cycle and registered.
REQ-018 SHALL drive wb_data_o to 0 whenever wb_ack_o is 0.
REQ-019 SHALL, on a read of MTIME_LO, capture MTIME_HI of the same cycle into a shadow register; a read of MTIME_HI SHALL return that shadow, so a LO-then-HI read pair is coherent.
REQ-020 SHALL keep a 64-bit mtime counter that increments by 1 each cycle while CTRL.bit1 is 1, wrapping from 2^64-1 to 0.
REQ-021 SHALL give a bus write to MTIME_LO or MTIME_HI priority over the increment in the same cycle: the written half takes the written bytes and the increment is skipped for the whole counter that cycle.
REQ-022 SHALL register irq_o as CTRL.bit0 AND (mtime >= mtimecmp), unsigned 64-bit compare, one cycle after the operands change.
REQ-023 SHALL drop a pending ack/err if wb_cyc_i is 0 in the cycle it would be driven; writes already accepted SHALL remain applied.

Reset
REQ-024 SHALL, with reset_i high at a clock edge, set:
- LED = 0, mtime = 0, mtimecmp = CmpReset, CTRL = 2'b10, shadow = 0.
- wb_ack_o = 0, wb_err_o = 0, wb_data_o = 0, irq_o = 0.
REQ-025 SHALL discard any request accepted in the same cycle reset_i is high, producing no ack, err or state change.

Structure
REQ-026 SHALL place the register offset constants and the CTRL bit-index constants in a shared package (riscv_pkg), so software headers and other peripherals use the same map.
REQ-027 SHALL implement as a single module with one natural sub-module, wb_slave_if, which handles acceptance, ack/err generation and the cyc-abort logic.

Verification
REQ-028 SHALL verify a write of 0x0000_000A to offset 0 with sel=4'b0001: ack one cycle later, leds_o = 4'b1010, readback = 0x0000_000A.
REQ-029 SHALL verify four back-to-back reads of offsets 0, 1, 5, 6: ack, ack, ack, err on four consecutive cycles, wb_stall_o = 0 throughout, and the CTRL read returns 0x0000_0002.
REQ-030 SHALL verify wrap: write MTIME_HI = 0xFFFF_FFFF then MTIME_LO = 0xFFFF_FFFE, wait 2 cycles, read LO then HI: values consistent with wrap through 0, and the HI read matches the shadow captured with LO.
REQ-031 SHALL verify the interrupt: write MTIMECMP_HI = 0, MTIMECMP_LO = 100, CTRL = 3: irq_o rises exactly one cycle after mtime reaches 100; writing CTRL = 2 clears irq_o next cycle.
REQ-032 SHALL verify the counter-write collision: a write to MTIME_LO of 0x10 in a cycle with count enable on gives mtime = 0x10 next cycle, not 0x11.
REQ-033 SHALL verify reset mid-operation: assert reset_i during the ack cycle of a read: wb_ack_o = 0 next cycle, all registers at reset values, and leds_o = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Register map and CTRL bit positions of the LED/timer peripheral, shared with
// software headers and other bus peripherals.
package riscv_pkg;

  localparam logic [2:0] REG_LED         = 3'd0;
  localparam logic [2:0] REG_MTIME_LO    = 3'd1;
  localparam logic [2:0] REG_MTIME_HI    = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd3;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd4;
  localparam logic [2:0] REG_CTRL        = 3'd5;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_CNT_EN = 1;

  function automatic logic is_mapped(input logic [2:0] offset);
    return offset <= REG_CTRL;
  endfunction

  // Replace only the bytes selected by a per-bit write mask.
  function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [31:0] mask);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/wb_slave_if.sv
// Pipelined Wishbone slave front end: request acceptance, single-cycle ack/err
// with registered read data, and suppression of responses when cyc drops.
module wb_slave_if
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] rdata,
  output logic        wr_en,
  output logic        rd_en,
  output logic        ack,
  output logic        err,
  output logic        stall,
  output logic [31:0] data
);

  logic        accept;
  logic        mapped;
  logic        ack_reg;
  logic        err_reg;
  logic [31:0] data_reg;

  // A request arriving together with reset is dropped entirely.
  assign accept = cyc && stb && !reset;
  assign mapped = is_mapped(addr);
  assign wr_en  = accept && we && mapped;
  assign rd_en  = accept && !we && mapped;
  assign stall  = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg  <= 1'b0;
      err_reg  <= 1'b0;
      data_reg <= '0;
    end else begin
      ack_reg  <= accept && mapped;
      err_reg  <= accept && !mapped;
      data_reg <= rd_en ? rdata : 32'd0;
    end
  end

  // The master abandoning the cycle swallows the response, not the write.
  assign ack  = ack_reg && cyc;
  assign err  = err_reg && cyc;
  assign data = ack ? data_reg : 32'd0;

endmodule

// File: rtl/wb_led_timer.sv
// Wishbone LED register plus a 64-bit mtime/mtimecmp timer with a
// level-sensitive interrupt.
module wb_led_timer
  import riscv_pkg::*;
#(
  parameter int          LedWidth = 4,
  parameter logic [63:0] CmpReset = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [29:0]         wb_addr_i,
  input  logic [31:0]         wb_data_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  output logic [31:0]         wb_data_o,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_stall_o,
  output logic [LedWidth-1:0] leds_o,
  output logic                irq_o
);

  logic [2:0]          addr;
  logic                wr_en;
  logic                rd_en;
  logic                wr_any;
  logic [31:0]         wmask;
  logic [31:0]         rdata;
  logic [LedWidth-1:0] led_reg;
  logic [63:0]         mtime_reg;
  logic [63:0]         cmp_reg;
  logic [1:0]          ctrl_reg;
  logic [31:0]         shadow_reg;
  logic                irq_reg;
  logic                unused_addr;

  assign addr        = wb_addr_i[2:0];
  assign unused_addr = ^wb_addr_i[29:3];

  wb_slave_if u_wb_slave_if (
    .clk   (clk_i),
    .reset (reset_i),
    .cyc   (wb_cyc_i),
    .stb   (wb_stb_i),
    .we    (wb_we_i),
    .addr  (addr),
    .rdata (rdata),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .ack   (wb_ack_o),
    .err   (wb_err_o),
    .stall (wb_stall_o),
    .data  (wb_data_o)
  );

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[8*gi +: 8] = {8{wb_sel_i[gi]}};
    end
  endgenerate

  // An all-zero byte select is a no-op write; it must not pause the counter.
  assign wr_any = wr_en && (wb_sel_i != 4'b0000);

  always_comb begin
    rdata = '0;
    case (addr)
      REG_LED:         rdata[LedWidth-1:0] = led_reg;
      REG_MTIME_LO:    rdata = mtime_reg[31:0];
      REG_MTIME_HI:    rdata = shadow_reg;
      REG_MTIMECMP_LO: rdata = cmp_reg[31:0];
      REG_MTIMECMP_HI: rdata = cmp_reg[63:32];
      REG_CTRL:        rdata[1:0] = ctrl_reg;
      default:         rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      led_reg    <= '0;
      mtime_reg  <= '0;
      cmp_reg    <= CmpReset;
      ctrl_reg   <= 2'b10;
      shadow_reg <= '0;
      irq_reg    <= 1'b0;
    end else begin
      if (wr_any) begin
        case (addr)
          REG_LED: led_reg <= (led_reg & ~wmask[LedWidth-1:0])
                            | (wb_data_i[LedWidth-1:0] & wmask[LedWidth-1:0]);
          REG_MTIMECMP_LO: cmp_reg[31:0]  <= merge_word(cmp_reg[31:0], wb_data_i, wmask);
          REG_MTIMECMP_HI: cmp_reg[63:32] <= merge_word(cmp_reg[63:32], wb_data_i, wmask);
          REG_CTRL: ctrl_reg <= (ctrl_reg & ~wmask[1:0]) | (wb_data_i[1:0] & wmask[1:0]);
          default: ;
        endcase
      end

      // A software write to either half freezes the whole counter for that cycle.
      if (wr_any && addr == REG_MTIME_LO) begin
        mtime_reg[31:0] <= merge_word(mtime_reg[31:0], wb_data_i, wmask);
      end else if (wr_any && addr == REG_MTIME_HI) begin
        mtime_reg[63:32] <= merge_word(mtime_reg[63:32], wb_data_i, wmask);
      end else if (ctrl_reg[CTRL_CNT_EN]) begin
        mtime_reg <= mtime_reg + 64'd1;
      end

      if (rd_en && addr == REG_MTIME_LO) begin
        shadow_reg <= mtime_reg[63:32];
      end

      irq_reg <= ctrl_reg[CTRL_IRQ_EN] && (mtime_reg >= cmp_reg);
    end
  end

  assign leds_o = led_reg;
  assign irq_o  = irq_reg;

endmodule

// File: tb/tb_wb_led_timer.sv
// Directed bench for wb_led_timer: a table of single bus transactions followed
// by hand-written pipelined, wrap, collision, abort, interrupt and reset sequences.
module tb_wb_led_timer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [29:0] wb_addr_i;
  logic [31:0] wb_data_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_data_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_stall_o;
  logic [3:0]  leds_o;
  logic        irq_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  wb_led_timer dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .wb_sel_i   (wb_sel_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_data_o  (wb_data_o),
    .wb_ack_o   (wb_ack_o),
    .wb_err_o   (wb_err_o),
    .wb_stall_o (wb_stall_o),
    .leds_o     (leds_o),
    .irq_o      (irq_o)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        exp_err;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [3:0]  exp_leds;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  // One request; response sampled on the negedge after the accepting posedge.
  task automatic bus(input logic we, input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic ack, output logic err,
                     output logic [31:0] rd);
    wb_cyc_i  = 1'b1;
    wb_stb_i  = 1'b1;
    wb_we_i   = we;
    wb_addr_i = {27'd0, a};
    wb_data_i = d;
    wb_sel_i  = s;
    @(posedge clk_i);
    @(negedge clk_i);
    ack = wb_ack_o;
    err = wb_err_o;
    rd  = wb_data_o;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic ack, err;
    logic [31:0] rd;
    bus(1'b1, a, d, 4'hF, ack, err, rd);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic ack, err;
    logic [31:0] rd;
    bus(1'b0, a, 32'd0, 4'hF, ack, err, rd);
    check({name, " ack"}, 32'(ack), 32'd1);
    check(name, rd, exp);
  endtask

  initial begin
    logic        ack, err;
    logic [31:0] rd;
    int          k;

    vecs[0]  = '{"led wr A",         1, 3'd0, 32'h0000_000A, 4'b0001, 0, 0, 32'h0,          4'hA};
    vecs[1]  = '{"led rd",           0, 3'd0, 32'h0,         4'b0001, 0, 1, 32'h0000_000A, 4'hA};
    vecs[2]  = '{"led wr sel0",      1, 3'd0, 32'hFFFF_FFF5, 4'b0000, 0, 0, 32'h0,          4'hA};
    vecs[3]  = '{"led rd sel0",      0, 3'd0, 32'h0,         4'b0000, 0, 1, 32'h0000_000A, 4'hA};
    vecs[4]  = '{"led wr 5",         1, 3'd0, 32'h0000_0005, 4'b0001, 0, 0, 32'h0,          4'h5};
    vecs[5]  = '{"led wr lane1",     1, 3'd0, 32'h0000_FFFF, 4'b0010, 0, 0, 32'h0,          4'h5};
    vecs[6]  = '{"led rd 5",         0, 3'd0, 32'h0,         4'b1111, 0, 1, 32'h0000_0005, 4'h5};
    vecs[7]  = '{"cmplo rd reset",   0, 3'd3, 32'h0,         4'b1111, 0, 1, 32'hFFFF_FFFF, 4'h5};
    vecs[8]  = '{"cmplo wr lanes",   1, 3'd3, 32'h1234_5678, 4'b0101, 0, 0, 32'h0,          4'h5};
    vecs[9]  = '{"cmplo rd lanes",   0, 3'd3, 32'h0,         4'b0010, 0, 1, 32'hFF34_FF78, 4'h5};
    vecs[10] = '{"cmplo restore",    1, 3'd3, 32'hFFFF_FFFF, 4'b1111, 0, 0, 32'h0,          4'h5};
    vecs[11] = '{"cmplo rd back",    0, 3'd3, 32'h0,         4'b1111, 0, 1, 32'hFFFF_FFFF, 4'h5};
    vecs[12] = '{"cmphi rd reset",   0, 3'd4, 32'h0,         4'b1111, 0, 1, 32'hFFFF_FFFF, 4'h5};
    vecs[13] = '{"ctrl rd reset",    0, 3'd5, 32'h0,         4'b1111, 0, 1, 32'h0000_0002, 4'h5};
    vecs[14] = '{"ctrl wr FE",       1, 3'd5, 32'hFFFF_FFFE, 4'b0001, 0, 0, 32'h0,          4'h5};
    vecs[15] = '{"ctrl rd 2",        0, 3'd5, 32'h0,         4'b1111, 0, 1, 32'h0000_0002, 4'h5};
    vecs[16] = '{"unmapped wr 6",    1, 3'd6, 32'hFFFF_FFFF, 4'b1111, 1, 1, 32'h0,          4'h5};
    vecs[17] = '{"unmapped rd 7",    0, 3'd7, 32'h0,         4'b1111, 1, 1, 32'h0,          4'h5};

    reset_i = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_addr_i = '0; wb_data_i = '0; wb_sel_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;

    check("reset ack",   32'(wb_ack_o),   32'd0);
    check("reset err",   32'(wb_err_o),   32'd0);
    check("reset data",  wb_data_o,       32'd0);
    check("reset leds",  32'(leds_o),     32'd0);
    check("reset irq",   32'(irq_o),      32'd0);
    check("reset stall", 32'(wb_stall_o), 32'd0);

    foreach (vecs[i]) begin
      bus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, ack, err, rd);
      check({vecs[i].name, " ack"}, 32'(ack), 32'(!vecs[i].exp_err));
      check({vecs[i].name, " err"}, 32'(err), 32'(vecs[i].exp_err));
      if (vecs[i].chk_data) check({vecs[i].name, " data"}, rd, vecs[i].exp_data);
      check({vecs[i].name, " leds"}, 32'(leds_o), 32'(vecs[i].exp_leds));
    end

    // Pipelined reads of offsets 0, 1, 5, 6 on consecutive cycles.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_addr_i = 30'd0;
    check("b2b stall0", 32'(wb_stall_o), 32'd0);
    @(posedge clk_i); @(negedge clk_i);
    check("b2b led ack", 32'(wb_ack_o), 32'd1);
    check("b2b led data", wb_data_o, 32'h5);
    check("b2b stall1", 32'(wb_stall_o), 32'd0);
    wb_addr_i = 30'd1;
    @(posedge clk_i); @(negedge clk_i);
    check("b2b mtlo ack", 32'(wb_ack_o), 32'd1);
    check("b2b mtlo err", 32'(wb_err_o), 32'd0);
    check("b2b stall2", 32'(wb_stall_o), 32'd0);
    wb_addr_i = 30'd5;
    @(posedge clk_i); @(negedge clk_i);
    check("b2b ctrl ack", 32'(wb_ack_o), 32'd1);
    check("b2b ctrl data", wb_data_o, 32'h2);
    check("b2b stall3", 32'(wb_stall_o), 32'd0);
    wb_addr_i = 30'd6;
    @(posedge clk_i); @(negedge clk_i);
    check("b2b off6 err", 32'(wb_err_o), 32'd1);
    check("b2b off6 ack", 32'(wb_ack_o), 32'd0);
    check("b2b off6 data", wb_data_o, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

    // Wrap: mtime = FFFF_FFFF_FFFF_FFFE, two increments reach 0.
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFE);
    repeat (2) @(negedge clk_i);
    rd_chk("wrap lo", 3'd1, 32'h0000_0000);
    rd_chk("wrap hi shadow", 3'd2, 32'h0000_0000);

    // Bus write wins over the increment.
    wr(3'd1, 32'h0000_0010);
    rd_chk("collision lo", 3'd1, 32'h0000_0010);

    // Write whose ack cycle sees cyc low: no ack, write still lands.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_addr_i = 30'd0; wb_data_i = 32'h3; wb_sel_i = 4'hF;
    @(posedge clk_i);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clk_i);
    check("abort ack", 32'(wb_ack_o), 32'd0);
    check("abort err", 32'(wb_err_o), 32'd0);
    check("abort leds", 32'(leds_o), 32'h3);

    // Interrupt at mtime == 100.
    wr(3'd5, 32'h0);
    wr(3'd2, 32'h0);
    wr(3'd1, 32'h0);
    wr(3'd3, 32'd100);
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h3);
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk_i);
      if (irq_o) begin
        k = c;
        break;
      end
    end
    check("irq rise cycle", 32'(k), 32'd101);
    wr(3'd5, 32'h2);
    check("irq held", 32'(irq_o), 32'd1);
    @(negedge clk_i);
    check("irq cleared", 32'(irq_o), 32'd0);

    // Reset asserted during the ack cycle of a read.
    wr(3'd5, 32'h1);
    wr(3'd0, 32'hF);
    check("pre-reset irq", 32'(irq_o), 32'd1);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 30'd0;
    @(posedge clk_i); @(negedge clk_i);
    check("pre-reset ack", 32'(wb_ack_o), 32'd1);
    check("pre-reset data", wb_data_o, 32'hF);
    wb_stb_i = 1'b0;
    reset_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    check("mid-reset ack", 32'(wb_ack_o), 32'd0);
    check("mid-reset data", wb_data_o, 32'd0);
    check("mid-reset leds", 32'(leds_o), 32'd0);
    check("mid-reset irq", 32'(irq_o), 32'd0);
    reset_i = 1'b0;
    wb_cyc_i = 1'b0;
    rd_chk("post-reset mtlo", 3'd1, 32'h0);
    rd_chk("post-reset mthi", 3'd2, 32'h0);
    rd_chk("post-reset cmplo", 3'd3, 32'hFFFF_FFFF);
    rd_chk("post-reset cmphi", 3'd4, 32'hFFFF_FFFF);
    rd_chk("post-reset ctrl", 3'd5, 32'h2);
    rd_chk("post-reset led", 3'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
